// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - per-switch synchroniser, debouncer and edge-pulse generator
// Optional feature macro: SW_DEBOUNCE_TOGGLE_EN (adds the sw_toggle output)
module sw_debounce #(
  parameter int N_SW            = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw,
  output logic [N_SW-1:0] sw_level,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall
`ifdef SW_DEBOUNCE_TOGGLE_EN
  ,
  output logic [N_SW-1:0] sw_toggle
`endif
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; the level commits there, so it never wraps.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic {
    STABLE   = 1'b0,
    SETTLING = 1'b1
  } state_t;

  logic [N_SW-1:0]  sync_ff [SYNC_STAGES];
  logic [N_SW-1:0]  sync;
  state_t           state   [N_SW];
  logic [CNT_W-1:0] cnt     [N_SW];
  logic [N_SW-1:0]  commit;
  logic [N_SW-1:0]  rise_nxt;
  logic [N_SW-1:0]  fall_nxt;

  assign sync = sync_ff[SYNC_STAGES-1];

  // Multi-flop synchroniser bringing the raw asynchronous switches into clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_ff[k] <= '0;
      end
    end else begin
      sync_ff[0] <= sw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_ff[k] <= sync_ff[k-1];
      end
    end
  end

  // Terminal-count detect per switch; shared by the FSM, the pulses and the toggle.
  always_comb begin
    commit   = '0;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < N_SW; i++) begin
      commit[i]   = (state[i] == SETTLING) && (sync[i] != sw_level[i]) && (cnt[i] == CNT_LAST);
      rise_nxt[i] = commit[i] & sync[i];
      fall_nxt[i] = commit[i] & ~sync[i];
    end
  end

  // Per-switch STABLE/SETTLING debounce FSM with registered level and edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_level <= '0;
      sw_rise  <= '0;
      sw_fall  <= '0;
      for (int i = 0; i < N_SW; i++) begin
        state[i] <= STABLE;
        cnt[i]   <= '0;
      end
    end else begin
      sw_rise <= rise_nxt;
      sw_fall <= fall_nxt;
      for (int i = 0; i < N_SW; i++) begin
        case (state[i])
          STABLE: begin
            if (sync[i] != sw_level[i]) begin
              state[i] <= SETTLING;
              cnt[i]   <= CNT_ONE;
            end else begin
              cnt[i] <= '0;
            end
          end
          SETTLING: begin
            if (sync[i] == sw_level[i]) begin
              // Bounced back before the stable time elapsed: drop the attempt.
              state[i] <= STABLE;
              cnt[i]   <= '0;
            end else if (commit[i]) begin
              sw_level[i] <= sync[i];
              state[i]    <= STABLE;
              cnt[i]      <= '0;
            end else begin
              cnt[i] <= cnt[i] + CNT_ONE;
            end
          end
          default: begin
            state[i] <= STABLE;
            cnt[i]   <= '0;
          end
        endcase
      end
    end
  end

`ifdef SW_DEBOUNCE_TOGGLE_EN
  // Toggle flop flips on the same edge that launches the rise pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_toggle <= '0;
    end else begin
      sw_toggle <= sw_toggle ^ rise_nxt;
    end
  end
`else
  // Toggle output and its state are not built in this configuration.
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - directed self-checking bench for sw_debounce
module tb_sw_debounce;

  logic       clk;
  logic       rst;
  logic [3:0] sw;
  logic [3:0] sw_level;
  logic [3:0] sw_rise;
  logic [3:0] sw_fall;
`ifdef SW_DEBOUNCE_TOGGLE_EN
  logic [3:0] sw_toggle;
`endif

  int n_vec;
  int n_err;
  int rise_cnt [4];
  int fall_cnt [4];
  int both_cnt;
  int base_r;
  int base_f;

  sw_debounce #(
    .N_SW           (4),
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .sw       (sw),
    .sw_level (sw_level),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall)
`ifdef SW_DEBOUNCE_TOGGLE_EN
    ,
    .sw_toggle(sw_toggle)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse monitor, sampled away from the active edge.
  initial begin
    for (int i = 0; i < 4; i++) begin
      rise_cnt[i] = 0;
      fall_cnt[i] = 0;
    end
    both_cnt = 0;
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (sw_rise[i]) rise_cnt[i] = rise_cnt[i] + 1;
      if (sw_fall[i]) fall_cnt[i] = fall_cnt[i] + 1;
      if (sw_rise[i] && sw_fall[i]) both_cnt = both_cnt + 1;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b1;
    sw    = 4'hF;

    // 1. reset held three cycles with all switches high
    for (int k = 0; k < 3; k++) begin
      tick(1);
      chk_eq("rst_level", 32'(sw_level), 32'h0);
      chk_eq("rst_pulses", 32'({sw_rise, sw_fall}), 32'h0);
    end
    rst = 1'b0;
    sw  = 4'h0;
    tick(1);
    chk_eq("post_rst_level", 32'(sw_level), 32'h0);
    chk_eq("post_rst_pulses", 32'({sw_rise, sw_fall}), 32'h0);
    tick(10);

    // 2. clean press and release on sw[0]
    sw[0] = 1'b1;
    tick(101);
    chk_eq("press_early", 32'(sw_level), 32'h0);
    tick(1);
    chk_eq("press_level", 32'(sw_level), 32'h1);
    chk_eq("press_rise", 32'(sw_rise), 32'h1);
    chk_eq("press_fall", 32'(sw_fall), 32'h0);
    tick(1);
    chk_eq("press_rise_1cyc", 32'(sw_rise), 32'h0);
    chk_eq("press_hold", 32'(sw_level), 32'h1);
    sw[0] = 1'b0;
    tick(101);
    chk_eq("rel_early", 32'(sw_level), 32'h1);
    tick(1);
    chk_eq("rel_level", 32'(sw_level), 32'h0);
    chk_eq("rel_fall", 32'(sw_fall), 32'h1);
    tick(1);
    chk_eq("rel_fall_1cyc", 32'(sw_fall), 32'h0);
    chk_eq("sw0_rise_total", 32'(rise_cnt[0]), 32'd1);
    chk_eq("sw0_fall_total", 32'(fall_cnt[0]), 32'd1);

    // 3. 60-cycle glitch on sw[1]
    sw[1] = 1'b1;
    tick(60);
    sw[1] = 1'b0;
    tick(150);
    chk_eq("glitch_level", 32'(sw_level[1]), 32'h0);
    chk_eq("glitch_pulses", 32'(rise_cnt[1] + fall_cnt[1]), 32'd0);

    // 4. bounce on sw[2]: toggles every 7 cycles for 70 cycles, then held high
    base_r = rise_cnt[2];
    base_f = fall_cnt[2];
    for (int s = 0; s < 10; s++) begin
      sw[2] = (s % 2 == 0) ? 1'b1 : 1'b0;
      tick(7);
    end
    chk_eq("bounce_no_level", 32'(sw_level[2]), 32'h0);
    sw[2] = 1'b1;
    tick(101);
    chk_eq("bounce_early", 32'(sw_level[2]), 32'h0);
    tick(1);
    chk_eq("bounce_level", 32'(sw_level[2]), 32'h1);
    chk_eq("bounce_rise", 32'(sw_rise), 32'h4);
    tick(20);
    chk_eq("bounce_one_rise", 32'(rise_cnt[2] - base_r), 32'd1);
    chk_eq("bounce_no_fall", 32'(fall_cnt[2] - base_f), 32'd0);

    // 5. reset in the middle of settling on sw[3]; sw[2] stays high throughout
    sw[3] = 1'b1;
    tick(50);
    rst = 1'b1;
    tick(1);
    chk_eq("midrst_level", 32'(sw_level), 32'h0);
    rst = 1'b0;
    tick(101);
    chk_eq("midrst_early", 32'(sw_level), 32'h0);
    tick(1);
    chk_eq("midrst_level_up", 32'(sw_level), 32'hC);
    chk_eq("midrst_rise", 32'(sw_rise), 32'hC);
    sw = 4'h0;
    tick(110);
    chk_eq("midrst_cleared", 32'(sw_level), 32'h0);

    // 6. all switches in parallel, from a fresh reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(5);
    sw = 4'hF;
    tick(102);
    chk_eq("par_rise", 32'(sw_rise), 32'hF);
    chk_eq("par_level", 32'(sw_level), 32'hF);
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk_eq("par_toggle1", 32'(sw_toggle), 32'hF);
`endif
    sw = 4'h0;
    tick(102);
    chk_eq("par_fall", 32'(sw_fall), 32'hF);
    chk_eq("par_level_low", 32'(sw_level), 32'h0);
    tick(5);
    sw = 4'hF;
    tick(102);
    chk_eq("par_rise2", 32'(sw_rise), 32'hF);
`ifdef SW_DEBOUNCE_TOGGLE_EN
    chk_eq("par_toggle2", 32'(sw_toggle), 32'h0);
`endif
    tick(3);
    chk_eq("never_both", 32'(both_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
